// File: rtl/maq_pkg.sv
// Shared constants, time bundles and hour stepping for the minutes/hours stage.
package maq_pkg;

   localparam logic [3:0] MIN_U_MAX    = 4'd9;
   localparam logic [2:0] MIN_T_MAX    = 3'd5;
   localparam logic [1:0] HOUR24_MAX_T = 2'd2;
   localparam logic [3:0] HOUR24_MAX_U = 4'd3;
   localparam logic [4:0] HOUR12_MAX   = 5'd12;

   localparam logic [1:0] HOUR12_T = 2'(HOUR12_MAX / 5'd10);
   localparam logic [3:0] HOUR12_U = 4'(HOUR12_MAX % 5'd10);

   typedef struct packed {
      logic [3:0] min_lsd;
      logic [2:0] min_msd;
      logic [3:0] hour_lsd;
      logic [1:0] hour_msd;
      logic       pm;
   } maq_time_t;

   typedef struct packed {
      logic [1:0] hour_msd;
      logic [3:0] hour_lsd;
      logic       pm;
      logic       day;
   } maq_hour_t;

   // Next hour in either format; day marks the midnight wrap.
   function automatic maq_hour_t hour_step(
      input logic       mode24,
      input logic [1:0] msd,
      input logic [3:0] lsd,
      input logic       pm
   );
      maq_hour_t r;
      logic      over;
      logic      mid;
      logic      tens;
      r = '{hour_msd: msd, hour_lsd: lsd, pm: pm, day: 1'b0};
      if (mode24) begin
         over = (msd > HOUR24_MAX_T) ||
                (msd == HOUR24_MAX_T && lsd >= HOUR24_MAX_U);
         mid  = 1'b0;
      end else begin
         over = (msd > HOUR12_T) ||
                (msd == HOUR12_T && lsd >= HOUR12_U);
         mid  = !over && msd == HOUR12_T &&
                lsd == (HOUR12_U - 4'd1);
      end
      tens = !over && !mid && lsd >= MIN_U_MAX;
      unique case (1'b1)
         over: begin
            r.hour_msd = 2'd0;
            r.hour_lsd = mode24 ? 4'd0 : 4'd1;
            r.day      = mode24;
         end
         mid: begin
            r.hour_lsd = HOUR12_U;
            r.pm       = ~pm;
            r.day      = pm;
         end
         tens: begin
            r.hour_msd = msd + 2'd1;
            r.hour_lsd = 4'd0;
         end
         default: begin
            r.hour_lsd = lsd + 4'd1;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/maq_bcd60.sv
// Two-digit BCD minute counter 00..59 with a suppressible wrap carry.
module maq_bcd60
   import maq_pkg::*;
(
   input  logic       maqs_clock,
   input  logic       maqs_reset,
   input  logic       inc,
   input  logic       carry_sup,
   output logic [3:0] lsd,
   output logic [2:0] msd,
   output logic       wrap
);

   logic u_top;
   logic t_top;

   assign u_top = lsd >= MIN_U_MAX;
   assign t_top = msd >= MIN_T_MAX;
   assign wrap  = inc & u_top & t_top & ~carry_sup;

   always_ff @(posedge maqs_clock or negedge maqs_reset) begin
      if (!maqs_reset) begin
         lsd <= '0;
         msd <= '0;
      end else if (inc) begin
         if (u_top) begin
            lsd <= '0;
            msd <= t_top ? 3'd0 : msd + 3'd1;
         end else begin
            lsd <= lsd + 4'd1;
         end
      end
   end

endmodule

// File: rtl/maq_mh.sv
// Minutes/hours stage: BCD minutes and hours, time-set path, day carry.
module maq_mh
   import maq_pkg::*;
#(
   parameter bit MODE_24H = 1'b1
) (
   input  logic       maqs_clock,
   input  logic       maqs_reset,
   input  logic       mh_enable,
   input  logic       mh_addminuto,
   input  logic       mh_set_en,
   input  logic       mh_set_min_inc,
   input  logic       mh_set_hour_inc,
   output logic [3:0] mh_min_Lsd,
   output logic [2:0] mh_min_Msd,
   output logic [3:0] mh_hour_Lsd,
   output logic [1:0] mh_hour_Msd,
   output logic       mh_pm,
   output logic       mh_addday
);

   localparam logic [1:0] RST_HT = MODE_24H ? 2'd0 : HOUR12_T;
   localparam logic [3:0] RST_HU = MODE_24H ? 4'd0 : HOUR12_U;

   logic       count_ev;
   logic       set_min;
   logic       set_hr;
   logic       min_inc;
   logic       min_wrap;
   logic       hour_inc;
   logic [3:0] min_lsd;
   logic [2:0] min_msd;
   logic [1:0] hour_msd_q;
   logic [3:0] hour_lsd_q;
   logic       pm_q;
   logic       addday_q;
   maq_hour_t  hour_nxt;
   maq_time_t  now_t;

   assign count_ev = mh_enable & mh_addminuto & ~mh_set_en;
   assign set_min  = mh_set_en & mh_set_min_inc;
   assign set_hr   = mh_set_en & mh_set_hour_inc;
   assign min_inc  = count_ev | set_min;
   assign hour_inc = min_wrap | set_hr;

   // Set-mode minute wraps must not carry into the hour.
   maq_bcd60 u_min (
      .maqs_clock (maqs_clock),
      .maqs_reset (maqs_reset),
      .inc        (min_inc),
      .carry_sup  (mh_set_en),
      .lsd        (min_lsd),
      .msd        (min_msd),
      .wrap       (min_wrap)
   );

   assign hour_nxt = hour_step(MODE_24H, hour_msd_q, hour_lsd_q, pm_q);

   always_ff @(posedge maqs_clock or negedge maqs_reset) begin
      if (!maqs_reset) begin
         hour_msd_q <= RST_HT;
         hour_lsd_q <= RST_HU;
         pm_q       <= 1'b0;
         addday_q   <= 1'b0;
      end else begin
         addday_q <= min_wrap & hour_nxt.day;
         if (hour_inc) begin
            hour_msd_q <= hour_nxt.hour_msd;
            hour_lsd_q <= hour_nxt.hour_lsd;
            pm_q       <= MODE_24H ? 1'b0 : hour_nxt.pm;
         end
      end
   end

   assign now_t = '{
      min_lsd:  min_lsd,
      min_msd:  min_msd,
      hour_lsd: hour_lsd_q,
      hour_msd: hour_msd_q,
      pm:       pm_q
   };

   assign mh_min_Lsd  = now_t.min_lsd;
   assign mh_min_Msd  = now_t.min_msd;
   assign mh_hour_Lsd = now_t.hour_lsd;
   assign mh_hour_Msd = now_t.hour_msd;
   assign mh_pm       = now_t.pm;
   assign mh_addday   = addday_q;

endmodule

// File: tb/tb_maq_mh.sv
// Bench for maq_mh: 24h and 12h instances against a decimal time model.
module tb_maq_mh;

   logic maqs_clock = 1'b0;
   logic maqs_reset = 1'b0;
   logic mh_enable = 1'b0;
   logic mh_addminuto = 1'b0;
   logic mh_set_en = 1'b0;
   logic mh_set_min_inc = 1'b0;
   logic mh_set_hour_inc = 1'b0;

   logic [3:0] a_ml, b_ml, a_hl, b_hl;
   logic [2:0] a_mm, b_mm;
   logic [1:0] a_hm, b_hm;
   logic       a_pm, b_pm, a_ad, b_ad;

   int checks = 0;
   int errors = 0;

   int mh[2];
   int mm[2];
   bit mpm[2];
   bit mday[2];

   always #5 maqs_clock = ~maqs_clock;

   maq_mh #(.MODE_24H(1'b1)) u24 (
      .maqs_clock      (maqs_clock),
      .maqs_reset      (maqs_reset),
      .mh_enable       (mh_enable),
      .mh_addminuto    (mh_addminuto),
      .mh_set_en       (mh_set_en),
      .mh_set_min_inc  (mh_set_min_inc),
      .mh_set_hour_inc (mh_set_hour_inc),
      .mh_min_Lsd      (a_ml),
      .mh_min_Msd      (a_mm),
      .mh_hour_Lsd     (a_hl),
      .mh_hour_Msd     (a_hm),
      .mh_pm           (a_pm),
      .mh_addday       (a_ad)
   );

   maq_mh #(.MODE_24H(1'b0)) u12 (
      .maqs_clock      (maqs_clock),
      .maqs_reset      (maqs_reset),
      .mh_enable       (mh_enable),
      .mh_addminuto    (mh_addminuto),
      .mh_set_en       (mh_set_en),
      .mh_set_min_inc  (mh_set_min_inc),
      .mh_set_hour_inc (mh_set_hour_inc),
      .mh_min_Lsd      (b_ml),
      .mh_min_Msd      (b_mm),
      .mh_hour_Lsd     (b_hl),
      .mh_hour_Msd     (b_hm),
      .mh_pm           (b_pm),
      .mh_addday       (b_ad)
   );

   function automatic void model_reset();
      mh[0] = 0;  mm[0] = 0; mpm[0] = 1'b0; mday[0] = 1'b0;
      mh[1] = 12; mm[1] = 0; mpm[1] = 1'b0; mday[1] = 1'b0;
   endfunction

   function automatic void hr_adv(int k);
      if (k == 0) begin
         mh[0] = (mh[0] + 1) % 24;
      end else if (mh[1] == 11) begin
         mh[1] = 12;
         mpm[1] = !mpm[1];
      end else if (mh[1] == 12) begin
         mh[1] = 1;
      end else begin
         mh[1] = mh[1] + 1;
      end
   endfunction

   function automatic void model_edge(int k, bit en, bit am,
                                      bit se, bit mi, bit hi);
      mday[k] = 1'b0;
      if (se) begin
         if (mi) mm[k] = (mm[k] + 1) % 60;
         if (hi) hr_adv(k);
      end else if (en && am) begin
         if (mm[k] == 59) begin
            mm[k] = 0;
            if (k == 0) mday[k] = (mh[0] == 23);
            else mday[k] = (mh[1] == 11 && mpm[1]);
            hr_adv(k);
         end else begin
            mm[k] = mm[k] + 1;
         end
      end
   endfunction

   task automatic check(input string tag);
      logic [14:0] o0, e0, o1, e1;
      o0 = {a_hm, a_hl, a_mm, a_ml, a_pm, a_ad};
      e0 = {2'(mh[0] / 10), 4'(mh[0] % 10), 3'(mm[0] / 10),
            4'(mm[0] % 10), mpm[0], mday[0]};
      o1 = {b_hm, b_hl, b_mm, b_ml, b_pm, b_ad};
      e1 = {2'(mh[1] / 10), 4'(mh[1] % 10), 3'(mm[1] / 10),
            4'(mm[1] % 10), mpm[1], mday[1]};
      checks++;
      assert (o0 === e0) else begin
         errors++;
         $error("FAIL %s/24h observed {hM,hL,mM,mL,pm,day}=%h expected %h",
                tag, o0, e0);
      end
      checks++;
      assert (o1 === e1) else begin
         errors++;
         $error("FAIL %s/12h observed {hM,hL,mM,mL,pm,day}=%h expected %h",
                tag, o1, e1);
      end
   endtask

   task automatic step(input bit en, input bit am, input bit se,
                       input bit mi, input bit hi, input string tag);
      mh_enable       = en;
      mh_addminuto    = am;
      mh_set_en       = se;
      mh_set_min_inc  = mi;
      mh_set_hour_inc = hi;
      @(posedge maqs_clock);
      model_edge(0, en, am, se, mi, hi);
      model_edge(1, en, am, se, mi, hi);
      #1;
      check(tag);
      mh_enable       = 1'b0;
      mh_addminuto    = 1'b0;
      mh_set_en       = 1'b0;
      mh_set_min_inc  = 1'b0;
      mh_set_hour_inc = 1'b0;
   endtask

   initial begin
      bit en, am, se, mi, hi;
      model_reset();
      #12;
      check("reset_hold");
      @(negedge maqs_clock);
      maqs_reset = 1'b1;
      step(0, 0, 0, 0, 0, "reset_idle");

      repeat (58) step(0, 0, 1, 1, 0, "set_min");
      step(1, 0, 0, 0, 0, "no_addminuto");
      step(0, 1, 0, 0, 0, "no_enable");
      step(1, 1, 0, 0, 0, "count_0059");

      repeat (23) step(0, 0, 1, 0, 1, "set_hour");
      step(1, 1, 0, 0, 0, "day_rollover");
      step(0, 0, 0, 0, 0, "addday_clear");

      while (!(mh[1] == 11 && !mpm[1])) step(0, 0, 1, 0, 1, "nav_am_h");
      while (mm[1] != 59) step(0, 0, 1, 1, 0, "nav_am_m");
      step(1, 1, 0, 0, 0, "am_to_pm");
      while (!(mh[1] == 11 && mpm[1])) step(0, 0, 1, 0, 1, "nav_pm_h");
      while (mm[1] != 59) step(0, 0, 1, 1, 0, "nav_pm_m");
      step(1, 1, 0, 0, 0, "pm_to_am");

      maqs_reset = 1'b0;
      model_reset();
      #1;
      check("reset_mid_addday");
      @(negedge maqs_clock);
      maqs_reset = 1'b1;

      while (mh[0] != 10) step(0, 0, 1, 0, 1, "nav_10_h");
      while (mm[0] != 59) step(0, 0, 1, 1, 0, "nav_10_m");
      step(0, 0, 1, 1, 1, "set_both");
      step(1, 1, 1, 0, 0, "count_frozen");
      step(0, 0, 0, 1, 1, "pulse_no_set");

      @(negedge maqs_clock);
      force u24.hour_lsd_q = 4'hF;
      #1;
      release u24.hour_lsd_q;
      mh[0] = (mh[0] / 10) * 10 + 9;
      step(0, 0, 1, 0, 1, "illegal_hour");

      repeat (700) begin
         en = ($urandom_range(0, 9) < 8);
         am = ($urandom_range(0, 2) != 0);
         se = ($urandom_range(0, 4) == 0);
         mi = 1'($urandom_range(0, 1));
         hi = 1'($urandom_range(0, 1));
         step(en, am, se, mi, hi, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
